// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and the
// operand-width bound used by the top module.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int MIN_BITS = 2;
  localparam int MAX_BITS = 32;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_bit.sv
// One-bit full adder cell used as the datapath of the serial adder.
module adder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule : adder_1bit

// File: rtl/serial_adder.sv
// Bit-serial NUM_BITS adder: one full-adder cell with a registered carry,
// LSB first, result and flags held until the next completion.
//
// state | meaning
// IDLE  | waiting for start
// ADD   | one bit pair per clock through the adder cell
// DONE  | single-cycle done pulse; start here chains the next add
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int CNT_W = $clog2(NUM_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(NUM_BITS - 2);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_BITS-1:0] a_sr_q, a_sr_d;
  logic [NUM_BITS-1:0] b_sr_q, b_sr_d;
  logic [NUM_BITS-1:0] res_sr_q, res_sr_d;
  logic                carry_q, carry_d;
  logic                c_msb_q, c_msb_d;
  logic [NUM_BITS-1:0] sum_q, sum_d;
  logic                cout_q, cout_d;
  logic                ovf_q, ovf_d;

  logic cell_s;
  logic cell_c;
  logic accept;

  adder_1bit u_cell (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .c_i (carry_q),
    .s_o (cell_s),
    .c_o (cell_c)
  );

  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          carry_d  = carry_in;
          c_msb_d  = 1'b0;
          count_d  = '0;
          state_d  = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        res_sr_d = {cell_s, res_sr_q[NUM_BITS-1:1]};
        a_sr_d   = {1'b0, a_sr_q[NUM_BITS-1:1]};
        b_sr_d   = {1'b0, b_sr_q[NUM_BITS-1:1]};
        carry_d  = cell_c;
        count_d  = count_q + CNT_W'(1);
        // Carry leaving bit N-2 is the carry into the MSB, needed for overflow.
        if (count_q == CNT_PENULT) begin
          c_msb_d = cell_c;
        end
        if (count_q == CNT_LAST) begin
          sum_d   = {cell_s, res_sr_q[NUM_BITS-1:1]};
          cout_d  = cell_c;
          ovf_d   = c_msb_q ^ cell_c;
          count_d = '0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign busy      = (state_q == ADD);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  a_start_known : assert property (@(posedge clk) disable iff (!n_rst) !$isunknown(start))
    else $error("serial_adder: start is X/Z");

  a_operands_known : assert property (@(posedge clk) disable iff (!n_rst)
    accept |-> !$isunknown({a, b, carry_in}))
    else $error("serial_adder: operands X/Z on accepted start");

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and random self-checking bench for serial_adder with NUM_BITS=8.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         n_rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_checks;
  int n_pass;

  serial_adder #(.NUM_BITS(N)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv);
    @(negedge clk);
    a        = av;
    b        = bv;
    carry_in = cv;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts busy and idle cycles seen before the done pulse, bounded.
  task automatic wait_done(output int busy_cnt, output int idle_cnt, output bit seen);
    busy_cnt = 0;
    idle_cnt = 0;
    seen     = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
      else idle_cnt++;
    end
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, sum, carry_out, overflow} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got busy=%0b done=%0b sum=%h cout=%0b ovf=%0b, need all 0",
               busy, done, sum, carry_out, overflow);
    else n_pass++;
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_after_reset: got busy=%0b done=%0b, need 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_basic;
    logic [N-1:0] va [3] = '{8'h3C, 8'hFF, 8'h7F};
    logic [N-1:0] vb [3] = '{8'h5A, 8'h01, 8'h00};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [N-1:0] es [3] = '{8'h96, 8'h00, 8'h80};
    logic         eco[3] = '{1'b0, 1'b1, 1'b0};
    logic         eov[3] = '{1'b1, 1'b0, 1'b1};
    int bc, ic;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vc[i]);
      wait_done(bc, ic, seen);
      n_checks++;
      if (!seen || bc != 8)
        $display("FAIL basic_latency[%0d]: got done_seen=%0b busy_cycles=%0d, need 1 and 8", i, seen, bc);
      else n_pass++;
      n_checks++;
      if ({sum, carry_out, overflow} !== {es[i], eco[i], eov[i]})
        $display("FAIL basic_result[%0d]: got sum=%h cout=%0b ovf=%0b, need sum=%h cout=%0b ovf=%0b",
                 i, sum, carry_out, overflow, es[i], eco[i], eov[i]);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        $display("FAIL basic_done_pulse[%0d]: got done=%0b busy=%0b after pulse, need 0 0", i, done, busy);
      else n_pass++;
    end
  endtask

  task automatic test_start_ignored;
    int bc, ic;
    bit seen;
    issue(8'h12, 8'h34, 1'b0);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF; carry_in = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done(bc, ic, seen);
    n_checks++;
    if (!seen || {sum, carry_out, overflow} !== {8'h46, 1'b0, 1'b0})
      $display("FAIL start_ignored: got seen=%0b sum=%h cout=%0b ovf=%0b, need 1 sum=46 cout=0 ovf=0",
               seen, sum, carry_out, overflow);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int bc, ic;
    bit seen;
    issue(8'h80, 8'h80, 1'b0);
    wait_done(bc, ic, seen);
    n_checks++;
    if (!seen || {sum, carry_out, overflow} !== {8'h00, 1'b1, 1'b1})
      $display("FAIL b2b_first: got seen=%0b sum=%h cout=%0b ovf=%0b, need 1 sum=00 cout=1 ovf=1",
               seen, sum, carry_out, overflow);
    else n_pass++;
    a = 8'h01; b = 8'h02; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || {sum, carry_out, overflow} !== {8'h00, 1'b1, 1'b1})
      $display("FAIL b2b_hold: got busy=%0b sum=%h cout=%0b ovf=%0b, need busy=1 held sum=00 cout=1 ovf=1",
               busy, sum, carry_out, overflow);
    else n_pass++;
    wait_done(bc, ic, seen);
    n_checks++;
    if (!seen || bc != 7 || ic != 0)
      $display("FAIL b2b_gap: got seen=%0b busy=%0d idle=%0d, need 1 7 0", seen, bc, ic);
    else n_pass++;
    n_checks++;
    if ({sum, carry_out, overflow} !== {8'h03, 1'b0, 1'b0})
      $display("FAIL b2b_result: got sum=%h cout=%0b ovf=%0b, need sum=03 cout=0 ovf=0",
               sum, carry_out, overflow);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_add;
    int bc, ic;
    bit seen;
    bit saw_done;
    issue(8'h55, 8'h22, 1'b1);
    repeat (4) @(negedge clk);
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0)
      $display("FAIL reset_mid_add: got busy=%0b sum=%h cout=%0b, need 0 00 0", busy, sum, carry_out);
    else n_pass++;
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_rst = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) $display("FAIL reset_no_done: got done pulse=%0b, need 0", saw_done);
    else n_pass++;
    issue(8'h55, 8'h22, 1'b1);
    wait_done(bc, ic, seen);
    n_checks++;
    if (!seen || {sum, carry_out, overflow} !== {8'h78, 1'b0, 1'b0})
      $display("FAIL reset_recover: got seen=%0b sum=%h cout=%0b ovf=%0b, need 1 sum=78 cout=0 ovf=0",
               seen, sum, carry_out, overflow);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_random;
    int bc, ic;
    bit seen;
    logic [N-1:0] av, bv, es;
    logic cv, eco, eov;
    logic [N:0] full;
    for (int i = 0; i < 1000; i++) begin
      av   = N'($urandom);
      bv   = N'($urandom);
      cv   = 1'($urandom_range(0, 1));
      full = {1'b0, av} + {1'b0, bv} + {8'h00, cv};
      es   = full[N-1:0];
      eco  = full[N];
      eov  = (av[N-1] == bv[N-1]) && (es[N-1] != av[N-1]);
      issue(av, bv, cv);
      wait_done(bc, ic, seen);
      n_checks++;
      if (!seen || bc != 8 || {sum, carry_out, overflow} !== {es, eco, eov})
        $display("FAIL random[%0d] a=%h b=%h cin=%0b: got seen=%0b busy=%0d sum=%h cout=%0b ovf=%0b, need 1 8 sum=%h cout=%0b ovf=%0b",
                 i, av, bv, cv, seen, bc, sum, carry_out, overflow, es, eco, eov);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL random_single_done[%0d]: got done=%0b, need 0", i, done);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_add();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_adder
